dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the pipelined core's data-memory bus (daddr/ddata_w/ddata_r/MemWrite/MemRead).
//  Registered-read word RAM in the lower half of the address space and a memory-mapped I/O window
//  in the upper half: free-running cycle counter, LED register and a byte console with a small
//  TX FIFO drained by a valid/ready consumer. Drop-in replacement for the plain data RAM in benches/FPGA top.
// PARAMETERS
//  ADDR_SIZE   10  word-address width; daddr[ADDR_SIZE-1]=0 -> RAM, =1 -> MMIO
//  DATA_SIZE   32  data word width (>=32)
//  LED_WIDTH   8   width of LED output register
//  FIFO_DEPTH  4   console FIFO entries, power of two, >=2
// PORTS
//  CLK       in   1          clock, all state on rising edge
//  RESET_N   in   1          asynchronous active-low reset
//  CLEAR     in   1          synchronous clear of MMIO state and FIFO (RAM contents untouched)
//  daddr     in   ADDR_SIZE  word address from core
//  MemWrite  in   1          write strobe, sampled on rising edge
//  MemRead   in   1          read strobe, sampled on rising edge
//  ddata_w   in   DATA_SIZE  write data
//  ddata_r   out  DATA_SIZE  read data, valid the cycle after MemRead
//  leds      out  LED_WIDTH  LED register
//  tx_data   out  8          console byte at FIFO head
//  tx_valid  out  1          FIFO non-empty
//  tx_ready  in   1          consumer accepts head when tx_valid&tx_ready
// BEHAVIOUR
//  Reset (RESET_N=0, async) and CLEAR (sync): ddata_r=0, leds=0, cycle=0, FIFO empty, tx_valid=0, ovf=0.
//  RAM: 2**(ADDR_SIZE-1) words, index daddr[ADDR_SIZE-2:0]; contents not reset.
//  Read: MemRead at edge N -> ddata_r holds addressed word after edge N; held until next MemRead edge.
//  Write: MemWrite at edge N updates target at edge N; a read issued at edge N+1 returns new value.
//  MemRead&MemWrite same edge, same address: read-first (ddata_r = old value), write still performed.
//  MMIO offset = daddr[2:0] inside MMIO window; daddr[ADDR_SIZE-2:3] ignored (aliasing).
//   0 CYCLE   RO  32-bit counter, +1 every cycle out of reset, wraps 0xFFFF_FFFF->0; writes ignored.
//                 Read returns value at the sampling edge.
//   1 LED     RW  write: leds <= ddata_w[LED_WIDTH-1:0]; read zero-extended.
//   2 CONSOLE WO  write pushes ddata_w[7:0]; read returns 0.
//   3 STATUS  R/W1C  bit0 full, bit1 empty, bit2 ovf (sticky), bits[3+:log2(FIFO_DEPTH)+1] level.
//                 Write with ddata_w[2]=1 clears ovf; other bits read-only.
//   4-7       reads 0, writes ignored.
//  Console FIFO:
//   push when CONSOLE written; pop when tx_valid&tx_ready. Level updates on same edge.
//   full & push & no pop -> byte dropped, ovf<=1, level unchanged.
//   full & push & pop -> both happen, level stays FIFO_DEPTH, no ovf.
//   empty & push -> tx_valid=1 the following cycle (no fall-through); tx_data stable while valid&!ready.
//   ovf set and W1C clear on same edge -> set wins.
//   Pointers wrap modulo FIFO_DEPTH; level width log2(FIFO_DEPTH)+1.
//  RESET_N mid-transfer: all MMIO/FIFO state lost immediately, tx_valid drops asynchronously.
// STRUCTURE
//  dmem_pkg: MMIO offset localparams (MMIO_CYCLE=0..MMIO_STATUS=3), STATUS bit positions.
//  Sub-module console_fifo (sync FIFO, params WIDTH=8, DEPTH; push/pop/full/empty/level, clear).
//  Top holds RAM array, address decode, cycle counter, LED, ovf, read mux register.
// TESTING
//  1 Reset: RESET_N=0 -> ddata_r=0, leds=0, tx_valid=0; release, read STATUS -> empty=1, level=0.
//  2 RAM: write 0xDEADBEEF @0x005, read @0x005 next cycle -> ddata_r=0xDEADBEEF one cycle later;
//    simultaneous RD+WR 0x12345678 @0x005 -> ddata_r=0xDEADBEEF, following read -> 0x12345678.
//  3 LED/CYCLE: write 0x1A5 to LED (0x201) -> leds=0xA5; two CYCLE reads 10 cycles apart differ by 10.
//  4 Console: tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS full=1, level=4, ovf=1; tx_ready=1 ->
//    drains 0x41..0x44 one per cycle, 0x45 never appears; write STATUS 0x4 -> ovf=0.
//  5 Full+push+pop same edge: FIFO full, tx_ready=1, push 0x55 -> level stays 4, ovf=0, 0x55 drained last.
//  6 Run instruction program to completion on core; async RESET_N pulse mid-drain -> tx_valid=0 at once.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - MMIO offsets and STATUS bit layout for dmem_responder
package dmem_responder_pkg;

  localparam logic [2:0] MMIO_CYCLE   = 3'd0;
  localparam logic [2:0] MMIO_LED     = 3'd1;
  localparam logic [2:0] MMIO_CONSOLE = 3'd2;
  localparam logic [2:0] MMIO_STATUS  = 3'd3;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_LEVEL  = 3;

  localparam int CYCLE_WIDTH = 32;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data-memory bus plus console stream
interface dmem_responder_if #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32,
  parameter int LED_WIDTH = 8
);
  logic [ADDR_SIZE-1:0] daddr;
  logic                 MemWrite;
  logic                 MemRead;
  logic [DATA_SIZE-1:0] ddata_w;
  logic [DATA_SIZE-1:0] ddata_r;
  logic [LED_WIDTH-1:0] leds;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output daddr, MemWrite, MemRead, ddata_w, tx_ready,
    input  ddata_r, leds, tx_data, tx_valid
  );

  modport slave (
    input  daddr, MemWrite, MemRead, ddata_w, tx_ready,
    output ddata_r, leds, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_responder_console_fifo.sv
// rtl/dmem_responder_console_fifo.sv - synchronous console byte FIFO, registered head
module dmem_responder_console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign w_pop   = i_pop & (r_level != '0);
  assign w_push  = i_push & ((r_level != LVL_FULL) | w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM low half, MMIO (cycle/LED/console) high half
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_SIZE  = 10,
  parameter int DATA_SIZE  = 32,
  parameter int LED_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CLEAR,
  dmem_responder_if.slave   bus
);
  localparam int RAM_WORDS = 2 ** (ADDR_SIZE - 1);
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_SIZE-1:0]   r_mem [RAM_WORDS];
  logic [DATA_SIZE-1:0]   r_rdata;
  logic [LED_WIDTH-1:0]   r_leds;
  logic [CYCLE_WIDTH-1:0] r_cycle;
  logic                   r_ovf;

  logic                   w_is_mmio;
  logic [ADDR_SIZE-2:0]   w_idx;
  logic [2:0]             w_off;
  logic                   w_mmio_wr;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_ovf_set;
  logic                   w_ovf_clr;
  logic                   w_full;
  logic                   w_empty;
  logic [LVL_W-1:0]       w_level;
  logic [7:0]             w_head;
  logic [DATA_SIZE-1:0]   w_status;
  logic [DATA_SIZE-1:0]   w_rd_data;

  assign w_is_mmio = bus.daddr[ADDR_SIZE-1];
  assign w_idx     = bus.daddr[ADDR_SIZE-2:0];
  assign w_off     = bus.daddr[2:0];
  assign w_mmio_wr = bus.MemWrite & w_is_mmio;
  assign w_push    = w_mmio_wr & (w_off == MMIO_CONSOLE);
  assign w_pop     = ~w_empty & bus.tx_ready;
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ovf_clr = w_mmio_wr & (w_off == MMIO_STATUS) & bus.ddata_w[STAT_OVF];

  dmem_responder_console_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_clear (CLEAR),
    .i_push  (w_push),
    .i_data  (bus.ddata_w[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_status                      = '0;
    w_status[STAT_FULL]           = w_full;
    w_status[STAT_EMPTY]          = w_empty;
    w_status[STAT_OVF]            = r_ovf;
    w_status[STAT_LEVEL +: LVL_W] = w_level;
  end

  // Reads sample pre-edge state, so a same-edge RAM write yields the old word.
  always_comb begin
    w_rd_data = '0;
    if (!w_is_mmio) begin
      w_rd_data = r_mem[w_idx];
    end else begin
      case (w_off)
        MMIO_CYCLE:  w_rd_data[CYCLE_WIDTH-1:0] = r_cycle;
        MMIO_LED:    w_rd_data[LED_WIDTH-1:0]   = r_leds;
        MMIO_STATUS: w_rd_data                  = w_status;
        default:     w_rd_data                  = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (bus.MemWrite && !w_is_mmio) r_mem[w_idx] <= bus.ddata_w;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rdata <= '0;
      r_leds  <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else if (CLEAR) begin
      r_rdata <= '0;
      r_leds  <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (bus.MemRead) r_rdata <= w_rd_data;
      if (w_mmio_wr && (w_off == MMIO_LED)) r_leds <= bus.ddata_w[LED_WIDTH-1:0];
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.ddata_r  = r_rdata;
  assign bus.leds     = r_leds;
  assign bus.tx_valid = ~w_empty;
  assign bus.tx_data  = w_head;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table, directed and randomized checks of dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_SIZE(10), .DATA_SIZE(32), .LED_WIDTH(8)) bus ();

  dmem_responder #(
    .ADDR_SIZE(10), .DATA_SIZE(32), .LED_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .CLEAR   (clear),
    .bus     (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [9:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic [7:0]  exp_leds;
  } vec_t;

  // Behavioural reference state: values visible after the most recent edge.
  logic [31:0] m_ram [16];
  logic [7:0]  m_q [$];
  logic [7:0]  m_leds;
  logic        m_ovf;
  logic [31:0] m_d;
  logic [31:0] m_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] a, input logic we, input logic re, input logic [31:0] wd);
    bus.daddr    = a;
    bus.MemWrite = we;
    bus.MemRead  = re;
    bus.ddata_w  = wd;
  endtask

  task automatic idle();
    drive(10'h000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push(input logic [7:0] b);
    drive(10'h202, 1'b1, 1'b0, {24'h0, b});
    tick();
    idle();
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    drive(a, 1'b0, 1'b1, 32'h0);
    tick();
    d = bus.ddata_r;
    idle();
  endtask

  task automatic drain(input int n_exp, input logic [7:0] exp_bytes [4], input string name);
    logic [7:0] got [$];
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_valid) got.push_back(bus.tx_data);
      tick();
    end
    bus.tx_ready = 1'b0;
    check({name, "_count"}, got.size(), n_exp);
    for (int i = 0; i < n_exp && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), {24'h0, got[i]}, {24'h0, exp_bytes[i]});
  endtask

  function automatic logic [31:0] model_read(input logic [9:0] a);
    logic [31:0] st;
    if (!a[9]) return m_ram[a[3:0]];
    case (a[2:0])
      3'd0: return m_cyc;
      3'd1: return {24'h0, m_leds};
      3'd3: begin
        st = 32'(m_q.size() == 4) | (32'(m_q.size() == 0) << 1) |
             (32'(m_ovf) << 2) | (32'(m_q.size()) << 3);
        return st;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic [9:0] a, input logic we, input logic re,
                            input logic [31:0] wd, input logic rdy, input logic clr);
    logic [31:0] nd;
    logic        pop, full, push, w1c, set;
    drive(a, we, re, wd);
    bus.tx_ready = rdy;
    clear        = clr;
    if (clr) begin
      m_d = 0; m_leds = 0; m_cyc = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      nd   = re ? model_read(a) : m_d;
      pop  = rdy && (m_q.size() > 0);
      full = (m_q.size() == 4);
      push = we && a[9] && (a[2:0] == 3'd2);
      w1c  = we && a[9] && (a[2:0] == 3'd3) && wd[2];
      set  = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (full && !pop) set = 1'b1;
        else m_q.push_back(wd[7:0]);
      end
      m_ovf = set ? 1'b1 : (w1c ? 1'b0 : m_ovf);
      if (we && a[9] && (a[2:0] == 3'd1)) m_leds = wd[7:0];
      if (we && !a[9]) m_ram[a[3:0]] = wd;
      m_d   = nd;
      m_cyc = m_cyc + 1;
    end
    tick();
    clear = 1'b0;
    check("rnd_ddata_r", bus.ddata_r, m_d);
    check("rnd_leds", {24'h0, bus.leds}, {24'h0, m_leds});
    check("rnd_tx_valid", {31'h0, bus.tx_valid}, {31'h0, m_q.size() > 0});
    if (m_q.size() > 0) check("rnd_tx_data", {24'h0, bus.tx_data}, {24'h0, m_q[0]});
  endtask

  vec_t        vecs [13];
  logic [31:0] d, c0, c1;
  logic [7:0]  exp4 [4];

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    bus.tx_ready = 1'b0;
    idle();
    #12;
    check("reset_ddata_r", bus.ddata_r, 32'h0);
    check("reset_leds", {24'h0, bus.leds}, 32'h0);
    check("reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    rd(10'h203, d);
    check("reset_status", d, 32'h2);

    vecs[0]  = '{10'h005, 1, 0, 32'hDEADBEEF, 32'h00000002, 8'h00};
    vecs[1]  = '{10'h005, 0, 1, 32'h0,        32'hDEADBEEF, 8'h00};
    vecs[2]  = '{10'h005, 1, 1, 32'h12345678, 32'hDEADBEEF, 8'h00};
    vecs[3]  = '{10'h005, 0, 1, 32'h0,        32'h12345678, 8'h00};
    vecs[4]  = '{10'h201, 1, 0, 32'h000001A5, 32'h12345678, 8'hA5};
    vecs[5]  = '{10'h201, 0, 1, 32'h0,        32'h000000A5, 8'hA5};
    vecs[6]  = '{10'h207, 0, 1, 32'h0,        32'h00000000, 8'hA5};
    vecs[7]  = '{10'h3F9, 0, 1, 32'h0,        32'h000000A5, 8'hA5};
    vecs[8]  = '{10'h202, 1, 0, 32'h00000141, 32'h000000A5, 8'hA5};
    vecs[9]  = '{10'h203, 0, 1, 32'h0,        32'h00000008, 8'hA5};
    vecs[10] = '{10'h202, 0, 1, 32'h0,        32'h00000000, 8'hA5};
    vecs[11] = '{10'h200, 1, 0, 32'hFFFFFFFF, 32'h00000000, 8'hA5};
    vecs[12] = '{10'h005, 1, 1, 32'hCAFEF00D, 32'h12345678, 8'hA5};
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wd);
      tick();
      check($sformatf("vec%0d_ddata_r", i), bus.ddata_r, vecs[i].exp_d);
      check($sformatf("vec%0d_leds", i), {24'h0, bus.leds}, {24'h0, vecs[i].exp_leds});
    end
    idle();
    check("console_head_valid", {31'h0, bus.tx_valid}, 32'h1);
    check("console_head_data", {24'h0, bus.tx_data}, 32'h41);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ddata_r", bus.ddata_r, 32'h0);
    check("clear_leds", {24'h0, bus.leds}, 32'h0);
    check("clear_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    rd(10'h005, d);
    check("clear_keeps_ram", d, 32'hCAFEF00D);

    rd(10'h200, c0);
    for (int i = 0; i < 9; i++) tick();
    rd(10'h200, c1);
    check("cycle_delta", c1 - c0, 32'd10);

    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
    rd(10'h203, d);
    check("overflow_status", d, 32'h25);
    exp4 = '{8'h41, 8'h42, 8'h43, 8'h44};
    drain(4, exp4, "overflow_drain");
    drive(10'h203, 1'b1, 1'b0, 32'h4);
    tick();
    rd(10'h203, d);
    check("ovf_w1c_status", d, 32'h2);

    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    drive(10'h202, 1'b1, 1'b0, 32'h55);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    rd(10'h203, d);
    check("full_push_pop_status", d, 32'h21);
    exp4 = '{8'h62, 8'h63, 8'h64, 8'h55};
    drain(4, exp4, "full_push_pop_drain");

    drive(10'h201, 1'b1, 1'b0, 32'h3C);
    tick();
    push(8'h71);
    push(8'h72);
    push(8'h73);
    bus.tx_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("async_reset_leds", {24'h0, bus.leds}, 32'h0);
    check("async_reset_ddata_r", bus.ddata_r, 32'h0);
    bus.tx_ready = 1'b0;
    tick();
    rst_n = 1'b1;

    model_step(10'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      model_step(10'(i), 1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 400; i++) begin
      int          kind;
      logic [9:0]  a;
      logic        we, re, clr;
      kind = $urandom_range(0, 49);
      clr  = (kind == 0);
      if (kind < 20) a = {6'h0, 4'($urandom_range(0, 15))};
      else if (kind < 44) a = {1'b1, 6'($urandom), 3'($urandom_range(0, 3))};
      else a = {1'b1, 6'($urandom), 3'($urandom_range(4, 7))};
      we = clr ? 1'b0 : 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      model_step(a, we, re, $urandom, 1'($urandom_range(0, 2) == 0), clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
